// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a common-anode multi-digit 7-segment display.
// One shared decoder is fed the nibble of the digit currently being scanned,
// each slot opens with a short all-dark guard interval against ghosting, and
// newly loaded data is double-buffered so it only takes effect between frames.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              hex_digit,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done,
  output logic                    load_ack
);

  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DATA_W = 4 * NUM_DIGITS;

  // Slot phase: BLANK keeps every anode dark, DRIVE lights the scanned digit.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   active_q, active_d;
  logic [DATA_W-1:0]   pending_q, pending_d;
  logic                pend_v_q, pend_v_d;
  logic [3:0]          hex_digit_q, hex_digit_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                frame_done_q, frame_done_d;
  logic                load_ack_q, load_ack_d;

  logic cnt_last;
  logic idx_last;
  logic boundary;

  // Slot counter, digit index and the frame boundary (last cycle of the last slot).
  always_comb begin
    cnt_last = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
    boundary = cnt_last && idx_last;
    cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (cnt_last) begin
      idx_d = idx_last ? '0 : idx_q + 1'b1;
    end
  end

  // Double buffer: pending is promoted at the boundary; a load on that same
  // edge becomes the next pending value instead of being lost.
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    if (boundary && pend_v_q) begin
      active_d = pending_q;
      pend_v_d = 1'b0;
    end
    if (load) begin
      pending_d = data_in;
      pend_v_d  = 1'b1;
    end
  end

  // Next slot phase, following where the counter lands on this edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_d >= CNT_W'(BLANK_CYCLES)) state_d = ST_DRIVE;
      ST_DRIVE: if (cnt_d <  CNT_W'(BLANK_CYCLES)) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  // Output values for the coming cycle, derived from next-state so the
  // registered outputs line up with the counter they describe.
  always_comb begin
    an_n_d = '1;
    if (state_d == ST_DRIVE) begin
      an_n_d[idx_d] = ~digit_en[idx_d];
    end
    hex_digit_d  = active_d[int'(idx_d) * 4 +: 4];
    frame_done_d = boundary;
    load_ack_d   = boundary && pend_v_q;
  end

  // State and output registers; reset darkens the anodes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_v_q     <= 1'b0;
      hex_digit_q  <= '0;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
      hex_digit_q  <= hex_digit_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
      load_ack_q   <= load_ack_d;
    end
  end

  assign hex_digit  = hex_digit_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;
  assign load_ack   = load_ack_q;

endmodule
